// File: rtl/stream_buffer_if.sv
// Stream handshake bundle for stream_buffer: upstream x_* and downstream y_* channels.
// The occupancy signal 'level' exists only when STREAM_BUFFER_LEVEL_EN is defined.
interface stream_buffer_if #(
    parameter int WIDTH = 32
`ifdef STREAM_BUFFER_LEVEL_EN
    , parameter int DEPTH = 4
`endif
);
    logic [WIDTH-1:0] x_data;
    logic             x_valid;
    logic             x_ready;
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
`ifdef STREAM_BUFFER_LEVEL_EN
    logic [$clog2(DEPTH+1)-1:0] level;
`endif

    // Environment view: feeds x_*, consumes y_*.
    modport master (
        output x_data, x_valid, y_ready,
        input  x_ready, y_data, y_valid
`ifdef STREAM_BUFFER_LEVEL_EN
        , input level
`endif
    );

    // Buffer view.
    modport slave (
        input  x_data, x_valid, y_ready,
        output x_ready, y_data, y_valid
`ifdef STREAM_BUFFER_LEVEL_EN
        , output level
`endif
    );
endinterface

// File: rtl/stream_buffer.sv
// Registered-output FIFO stream buffer, DEPTH entries (power of two), latency 1.
// Define STREAM_BUFFER_LEVEL_EN to expose the registered occupancy on bus.level.
module stream_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             xr;
    logic             yv;
    logic             push;
    logic             pop;

    // Handshake flags are registered so that they read 0 during reset even though count is already 0.
    always_comb begin
        push      = bus.x_valid && xr && !rst;
        pop       = yv && bus.y_ready && !rst;
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            xr    <= 1'b0;
            yv    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count_nxt;
            xr    <= (count_nxt != CW'(DEPTH));
            yv    <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= bus.x_data;
    end

    assign bus.x_ready = xr;
    assign bus.y_valid = yv;
    assign bus.y_data  = mem[rptr];
`ifdef STREAM_BUFFER_LEVEL_EN
    assign bus.level   = count;
`endif
endmodule

// File: doc/stream_buffer.md
STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, >=1.
- REQ-002 SHALL have parameter DEPTH, default 4: entry count, a power of two, >=2.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port x_data, input, WIDTH: upstream payload.
- REQ-006 SHALL have port x_valid, input, 1: upstream offers x_data.
- REQ-007 SHALL have port x_ready, output, 1: buffer can accept this cycle.
- REQ-008 SHALL have port y_data, output, WIDTH: downstream payload, the oldest stored entry.
- REQ-009 SHALL have port y_valid, output, 1: y_data holds a stored entry.
- REQ-010 SHALL have port y_ready, input, 1: downstream accepts.
- REQ-011 SHALL have port level, output, $clog2(DEPTH+1), only with STREAM_BUFFER_LEVEL_EN: current occupancy.

Function
- REQ-012 SHALL push on x_valid&&x_ready and pop on y_valid&&y_ready, each evaluated at the rising edge.
- REQ-013 SHALL drive x_ready = (count != DEPTH) and y_valid = (count != 0), from registered state only; no combinational path from x_valid or y_ready to any output.
- REQ-014 SHALL deliver entries in strict FIFO order with no loss, duplication or reordering.
- REQ-015 SHALL have latency 1: a word pushed into an empty buffer appears on y_data with y_valid=1 the next cycle; no same-cycle fall-through.
- REQ-016 SHALL keep y_data stable while y_valid=1 and y_ready=0.
- REQ-017 SHALL, on simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
- REQ-018 SHALL, when full, hold x_ready=0 even if y_ready=1 that cycle; the slot frees on the following cycle.
- REQ-019 SHALL, when empty, ignore y_ready; y_data is don't-care while y_valid=0.
- REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, and a count of $clog2(DEPTH+1) bits saturating at neither end (protocol prevents overflow/underflow).
- REQ-021 SHALL ignore x_data whenever no push occurs; storage written only on push.
- REQ-022 SHALL sustain one transfer per cycle in steady state when 0<count<DEPTH and both sides are active.

Reset
- REQ-023 SHALL, while rst=1, set count=0, both pointers=0, x_ready=0, y_valid=0, level=0; storage contents need not reset.
- REQ-024 SHALL drive x_ready=1 in the first cycle after rst deasserts.
- REQ-025 SHALL, on rst asserted mid-operation, discard all stored entries; no push or pop takes effect in a reset cycle.

Configuration
- REQ-026 SHALL, with STREAM_BUFFER_LEVEL_EN defined, expose port level equal to registered count, updated in the same edge as count.
- REQ-027 SHALL, without STREAM_BUFFER_LEVEL_EN, omit port level entirely; all other behaviour identical.

Verification
- REQ-028 SHALL cover: WIDTH=32 DEPTH=4, reset, push 0xDEADBEEF with y_ready=0 -> next cycle y_valid=1, y_data=0xDEADBEEF, level=1.
- REQ-029 SHALL cover: push 1,2,3,4 with y_ready=0 -> x_ready=0 after the 4th push, level=4; a 5th offer (5) is not accepted; then y_ready=1 -> outputs 1,2,3,4 in order, then y_valid=0.
- REQ-030 SHALL cover: full buffer, x_valid=1 and y_ready=1 in same cycle -> pop of 1 only, x_ready=1 next cycle, level=3.
- REQ-031 SHALL cover: continuous x_valid=1, y_ready=1, values 0..99 -> all 100 received in order, one per cycle after a 1-cycle initial latency, pointers wrapping 25 times.
- REQ-032 SHALL cover: level=3, assert rst for one cycle with x_valid=1,y_ready=1 -> y_valid=0, level=0 during reset, x_ready=1 the cycle after, no stale word ever appears.
- REQ-033 SHALL cover: random x_valid/y_ready (50% each) over 10000 cycles against a reference queue model -> zero mismatches, y_data stable under backpressure.
